// File: rtl/fir_result_reader.sv
// Purpose: reads a filled 256x26 FIR output memory out sequentially and streams each word on valid/ready with a last flag.
// Ports:   clk/reset, start/num_words/busy/done control, mem_* read port (never writes), out_* result stream.
// Latency: first out_valid 2 cycles after the first read issue; up to 1 word/cycle sustained.
// Backpressure: reads stall once buffered plus in-flight words fill the 2-entry skid buffer; head word holds while out_ready=0.
module fir_result_reader #(
   parameter int DATA_W    = 26,
   parameter int ADDR_W    = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W:0]     num_words,
   output logic                busy,
   output logic                done,
   output logic                mem_nce,
   output logic                mem_nwrt,
   output logic [ADDR_W-3:0]   mem_ra,
   output logic [1:0]          mem_ca,
   input  logic [DATA_W-1:0]   mem_do,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);

   localparam int              MAX_WORDS_I = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_WORDS   = MAX_WORDS_I[ADDR_W:0];

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   addr_q, addr_d;   // one bit wider than the memory address so it never wraps
   logic [ADDR_W:0]   len_q, len_d;
   logic              inflight_q;        // a read was issued last cycle; mem_do is valid now
   logic              inflight_last_q;

   logic [DATA_W-1:0] buf_dat_q  [BUF_DEPTH];
   logic              buf_last_q [BUF_DEPTH];
   logic              rd_ptr_q, wr_ptr_q;
   logic [1:0]        cnt_q;

   logic              pop, push, issue, issue_last, drain_empty;
   logic [2:0]        used;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = buf_dat_q[rd_ptr_q];
   assign out_last  = out_valid & buf_last_q[rd_ptr_q];
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q;

   // Slots that will be occupied after this edge, not counting a new read.
   // Counting the word leaving this cycle lets reads continue back-to-back
   // at 1 word/cycle while still never overrunning the buffer.
   assign used       = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
   assign issue      = (state_q == S_READ) && (used < 3'(BUF_DEPTH));
   assign issue_last = (addr_q == len_q - 1'b1);

   // Nothing pending after this edge: buffer empties and no read returns.
   assign drain_empty = !inflight_q && ((cnt_q == 2'd0) || (cnt_q == 2'd1 && pop));

   assign mem_nce  = ~issue;
   assign mem_nwrt = 1'b1;
   assign mem_ra   = addr_q[ADDR_W-1:2];
   assign mem_ca   = addr_q[1:0];
   assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  state_d = S_DONE;
               end else begin
                  len_d   = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                  addr_d  = '0;
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            if (issue) begin
               addr_d = addr_q + 1'b1;
               if (issue_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_empty) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         len_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         len_q           <= len_d;
         inflight_q      <= issue;
         inflight_last_q <= issue & issue_last;
      end
   end

   // Skid buffer: the returning word is written the edge after its read issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_dat_q[i]  <= '0;
            buf_last_q[i] <= 1'b0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            buf_dat_q[wr_ptr_q]  <= mem_do;
            buf_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_fir_result_reader.sv
// Purpose: randomized bench for fir_result_reader with a memory model and a word-queue reference model.
// Ports:   none; drives the DUT clock, reset, start/num_words, out_ready and the memory read data.
// Latency/backpressure: out_ready patterns include always-1, toggle, random and held-low stalls.
module tb_fir_result_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  num_words = '0;
   logic        busy, done, mem_nce, mem_nwrt;
   logic [5:0]  mem_ra;
   logic [1:0]  mem_ca;
   logic [25:0] mem_do = '0;
   logic [25:0] out_data;
   logic        out_valid, out_last;
   logic        out_ready = 1'b0;

   fir_result_reader dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .busy(busy), .done(done), .mem_nce(mem_nce), .mem_nwrt(mem_nwrt),
      .mem_ra(mem_ra), .mem_ca(mem_ca), .mem_do(mem_do),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [25:0] dat;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [25:0] mem [256];
   int          checks = 0, errors = 0;
   int          cyc = 0;
   int          ready_mode = 3;   // 0: always 1, 1: toggle, 2: random, 3: held 0
   int          issues, hs, dones, first_issue, first_valid, last_hs_cyc, done_expected_at;
   logic [25:0] first_hs_dat, last_hs_dat;
   logic [5:0]  last_ra;
   logic [1:0]  last_ca;
   logic        hold_pending = 1'b0;
   logic [25:0] hold_dat;
   logic        hold_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Read-only memory macro: data appears the cycle after an enabled edge.
   always @(posedge clk) begin
      cyc++;
      if (!mem_nce) mem_do <= mem[{mem_ra, mem_ca}];
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Compare process: every cycle, mid-period.
   always @(negedge clk) begin
      if (reset) begin
         hold_pending = 1'b0;
      end else begin
         if (!mem_nce) begin
            issues++;
            last_ra = mem_ra;
            last_ca = mem_ca;
            if (first_issue < 0) first_issue = cyc;
            chk("mem_nwrt_on_read", {31'd0, mem_nwrt}, 32'd1);
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (hold_pending) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {6'd0, out_data}, {6'd0, hold_dat});
            chk("hold_last", {31'd0, out_last}, {31'd0, hold_last});
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word actual=%0h required=none at cycle %0d", out_data, cyc);
            end else begin
               chk("out_data", {6'd0, out_data}, {6'd0, exp_q[0].dat});
               chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
               if (out_ready) begin
                  if (hs == 0) first_hs_dat = exp_q[0].dat;
                  if (exp_q[0].last) begin
                     last_hs_dat      = exp_q[0].dat;
                     done_expected_at = cyc + 1;
                  end
                  last_hs_cyc = cyc;
                  hs++;
                  void'(exp_q.pop_front());
               end
            end
         end
         hold_pending = out_valid && !out_ready;
         hold_dat     = out_data;
         hold_last    = out_last;
         if (done || cyc == done_expected_at) begin
            if (done) dones++;
            chk("done_timing", {31'd0, done}, {31'd0, cyc == done_expected_at});
            chk("busy_at_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_nce"}, {31'd0, mem_nce}, 32'd1);
      chk({tag, "_nwrt"}, {31'd0, mem_nwrt}, 32'd1);
      chk({tag, "_ra_ca"}, {24'd0, mem_ra, mem_ca}, 32'd0);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
      chk({tag, "_data"}, {6'd0, out_data}, 32'd0);
   endtask

   // Reference model: a run of nw words yields mem[0..n-1], n = min(nw,256), last on n-1.
   task automatic prepare(input int nw, input int mode, output int n);
      n = (nw > 256) ? 256 : nw;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back({mem[i], i == n - 1});
      issues = 0; hs = 0; dones = 0;
      first_issue = -1; first_valid = -1; last_hs_cyc = -1; done_expected_at = -1;
      ready_mode = mode;
      num_words  = 9'(nw);
   endtask

   task automatic pulse_start(output int c);
      @(posedge clk); #1;
      start = 1'b1;
      c = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 4000 && dones == 0; k++) begin
         @(negedge clk); #1;
      end
      if (dones == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_done required=done", tag);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input string tag, input int nw, input int mode, input bit repulse);
      int n, c;
      prepare(nw, mode, n);
      @(posedge clk);
      pulse_start(c);
      if (n == 0) done_expected_at = c + 1;
      chk({tag, "_busy_after_start"}, {31'd0, busy}, {31'd0, n > 0});
      if (repulse) begin
         repeat (20) @(posedge clk);
         #1;
         num_words = 9'd5;
         start     = 1'b1;
         @(posedge clk); #1;
         start     = 1'b0;
      end
      wait_done(tag);
      chk({tag, "_words_left"}, exp_q.size(), 32'd0);
      chk({tag, "_handshakes"}, hs, n);
      chk({tag, "_reads"}, issues, n);
      chk({tag, "_done_pulses"}, dones, 32'd1);
   endtask

   initial begin
      int n, c, r;
      #2 reset = 1'b1;
      #1 check_reset_outputs("reset0");
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;

      // 1: ramp pattern, full-rate consumer
      for (int i = 0; i < 256; i++) mem[i] = 26'(i * 3 - 100);
      run("t1", 8, 0, 1'b0);
      chk("t1_first_word", {6'd0, first_hs_dat}, {6'd0, 26'h3FFFF9C});  // -100
      chk("t1_last_word", {6'd0, last_hs_dat}, {6'd0, 26'h3FFFFB1});    // -79
      chk("t1_valid_latency", first_valid - first_issue, 32'd2);

      // 2: full memory, alternating ready
      for (int i = 0; i < 256; i++) mem[i] = 26'($urandom);
      run("t2", 256, 1, 1'b0);
      chk("t2_last_ra", {26'd0, last_ra}, 32'd63);
      chk("t2_last_ca", {30'd0, last_ca}, 32'd3);

      // 3: zero-length run
      run("t3", 0, 0, 1'b0);
      chk("t3_no_valid", first_valid, 32'hFFFFFFFF);

      // 4: consumer stalls 10 cycles after the first word appears
      prepare(12, 3, n);
      repeat (2) @(posedge clk);
      pulse_start(c);
      for (int k = 0; k < 50 && first_valid < 0; k++) @(negedge clk);
      repeat (10) @(posedge clk);
      #2 chk("t4_reads_during_stall", issues, 32'd2);
      @(posedge clk);
      ready_mode = 0;
      #1 r = cyc;
      wait_done("t4");
      chk("t4_stream_rate", last_hs_cyc, r + n - 1);
      chk("t4_handshakes", hs, n);

      // 5: reset in the middle of a 20-word run, then a short run
      for (int i = 0; i < 256; i++) mem[i] = 26'($urandom);
      prepare(20, 0, n);
      pulse_start(c);
      for (int k = 0; k < 100 && hs < 5; k++) begin
         @(negedge clk); #1;
      end
      chk("t5_reached_word5", hs, 32'd5);
      @(posedge clk); #1;
      reset = 1'b1;
      #1 check_reset_outputs("t5_midrun");
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      run("t5b", 4, 0, 1'b0);

      // 6: oversize length with a start re-pulsed while busy
      run("t6", 300, 2, 1'b1);

      // randomized runs
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 256; i++) mem[i] = 26'($urandom);
         run("rand", int'($urandom_range(1, 300)), 2, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
